gpio_pin_ctrl: RTL

Pin-side stage of one GPIO port, downstream of the GPIO register file. Drives the port's pads from the output and tristate registers. Synchronises and glitch-filters the pad inputs into the pinstate value. Raises per-pin edge interrupts toward the core. The block instantiates once per port (00..15).

---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_sync_filter.sv | 51 +++++
 rtl/gpio_pin_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared constants for the GPIO port blocks
package gpio_pkg;

  localparam int GPIO_WIDTH        = 32;
  localparam int GPIO_SYNC_STAGES  = 2;
  localparam int FILTER_DEPTH      = 3;

  // Byte offsets of the port registers, shared with the register file.
  typedef enum logic [7:0] {
    REG_OUTPUT    = 8'h00,
    REG_TRISTATE  = 8'h04,
    REG_PINSTATE  = 8'h08,
    REG_DATAREG   = 8'h0C,
    REG_INTERRUPT = 8'h10
  } gpio_reg_e;

endpackage

// File: rtl/gpio_sync_filter.sv
// rtl/gpio_sync_filter.sv - pad input synchroniser and 3-sample majority-free level filter
module gpio_sync_filter
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pinstate,
  output logic [WIDTH-1:0] pinstate_nxt
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q [FILTER_DEPTH-1];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] stable;

  assign sync_in = sync_q[SYNC_STAGES-1];

  // A bit may only move once the current sample matches every stored one.
  always_comb begin
    stable = '1;
    for (int i = 0; i < FILTER_DEPTH-1; i++) begin
      stable = stable & ~(sync_in ^ hist_q[i]);
    end
    pinstate_nxt = pinstate;
    if (tick) begin
      pinstate_nxt = (stable & sync_in) | (~stable & pinstate);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int i = 0; i < FILTER_DEPTH-1; i++) hist_q[i] <= '0;
      pinstate <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      if (tick) begin
        hist_q[0] <= sync_in;
        for (int i = 1; i < FILTER_DEPTH-1; i++) hist_q[i] <= hist_q[i-1];
      end
      pinstate <= pinstate_nxt;
    end
  end

endmodule

// File: rtl/gpio_pin_ctrl.sv
// rtl/gpio_pin_ctrl.sv - GPIO pad drive, filtered input sampling and edge interrupts
module gpio_pin_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DIV         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] out_val,
  input  logic [WIDTH-1:0] tri_en,
  input  logic [WIDTH-1:0] irq_rise,
  input  logic [WIDTH-1:0] irq_fall,
  input  logic [WIDTH-1:0] irq_clr,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic [WIDTH-1:0] pinstate,
  output logic [WIDTH-1:0] irq_pend,
  output logic             irq
);

  localparam int             CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [WIDTH-1:0] pinstate_nxt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set;

  // With DIV=1 CNT_MAX is 0 and cnt never leaves 0, so tick is held high.
  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  gpio_sync_filter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .pin_in       (pin_in),
    .pinstate     (pinstate),
    .pinstate_nxt (pinstate_nxt)
  );

  // Edges come from the filter's next value so pend lands with pinstate.
  assign rise = pinstate_nxt & ~pinstate;
  assign fall = ~pinstate_nxt & pinstate;
  assign set  = (rise & irq_rise) | (fall & irq_fall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_out  <= '0;
      pin_oe   <= '0;
      irq_pend <= '0;
      irq      <= 1'b0;
    end else begin
      pin_out  <= out_val;
      pin_oe   <= ~tri_en;
      irq_pend <= (irq_pend & ~irq_clr) | set;
      irq      <= |irq_pend;
    end
  end

endmodule
